// File: rtl/pipe_reg_hs.sv
// ============================================================================
// Module   : pipe_reg_hs
// Purpose  : Parametrised valid/ready pipeline stage register. Carries a data
//            bundle and a control bundle between two pipeline stages, with
//            back-pressure (optional skid entry), flush-to-bubble, control
//            gating on empty slots and a saturating stall counter.
//            All state changes on the falling edge of clk, like the rest of
//            the pipeline.
// Ports    : clk        - pipeline clock (falling-edge active)
//            rst        - synchronous active-high reset
//            flush      - turn the stage into a bubble
//            in_valid   - upstream slot holds a real instruction
//            in_ready   - stage accepts in_data/in_ctrl this cycle
//            in_data    - upstream data bundle   [DATA_W]
//            in_ctrl    - upstream control bundle [CTRL_W]
//            out_valid  - out_data/out_ctrl hold a real instruction
//            out_ready  - downstream accepts this cycle (0 = stall)
//            out_data   - registered data bundle  [DATA_W]
//            out_ctrl   - registered control bundle [CTRL_W]
//            stall_cnt  - saturating count of out_valid & !out_ready cycles
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_reg_hs #(
  parameter int DATA_W    = 128,
  parameter int CTRL_W    = 16,
  parameter int SKID      = 1,
  parameter int GATE_CTRL = 1,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              w_main_valid;
  logic [DATA_W-1:0] w_main_data;
  logic [CTRL_W-1:0] w_main_ctrl;
  logic              w_in_ready;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  generate
    if (SKID != 0) begin : g_skid
      typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL  = 2'd1,
        S_SKIDF = 2'd2
      } state_t;

      state_t            state_q, state_d;
      logic [DATA_W-1:0] main_data_q, main_data_d;
      logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
      logic [DATA_W-1:0] skid_data_q, skid_data_d;
      logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
      logic              in_ready_q;
      logic              w_in_fire;
      logic              w_out_fire;

      assign w_in_fire  = in_valid & in_ready_q;
      assign w_out_fire = (state_q != S_EMPTY) & out_ready;

      always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        case (state_q)
          S_EMPTY: begin
            if (w_in_fire) begin
              state_d     = S_FULL;
              main_data_d = in_data;
              main_ctrl_d = in_ctrl;
            end
          end
          S_FULL: begin
            if (w_in_fire && w_out_fire) begin
              main_data_d = in_data;
              main_ctrl_d = in_ctrl;
            end else if (w_in_fire) begin
              // Downstream stalled: park the younger word in the skid entry.
              state_d     = S_SKIDF;
              skid_data_d = in_data;
              skid_ctrl_d = in_ctrl;
            end else if (w_out_fire) begin
              state_d = S_EMPTY;
            end
          end
          S_SKIDF: begin
            if (w_out_fire) begin
              state_d     = S_FULL;
              main_data_d = skid_data_q;
              main_ctrl_d = skid_ctrl_q;
              skid_data_d = '0;
              skid_ctrl_d = '0;
            end
          end
          default: begin
            state_d = S_EMPTY;
          end
        endcase
        // Flush overrides the handshake; any word accepted this cycle is lost.
        if (flush) begin
          state_d     = S_EMPTY;
          main_data_d = '0;
          main_ctrl_d = '0;
        end
      end

      always_ff @(negedge clk) begin
        if (rst) begin
          state_q     <= S_EMPTY;
          main_data_q <= '0;
          main_ctrl_q <= '0;
          skid_data_q <= '0;
          skid_ctrl_q <= '0;
          in_ready_q  <= 1'b1;
        end else begin
          state_q     <= state_d;
          main_data_q <= main_data_d;
          main_ctrl_q <= main_ctrl_d;
          skid_data_q <= skid_data_d;
          skid_ctrl_q <= skid_ctrl_d;
          // Registered ready: low only while both entries are occupied.
          in_ready_q  <= (state_d != S_SKIDF);
        end
      end

      assign w_main_valid = (state_q != S_EMPTY);
      assign w_main_data  = main_data_q;
      assign w_main_ctrl  = main_ctrl_q;
      assign w_in_ready   = in_ready_q;
    end else begin : g_noskid
      logic              main_valid_q, main_valid_d;
      logic [DATA_W-1:0] main_data_q, main_data_d;
      logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
      logic              w_in_fire;
      logic              w_out_fire;

      // Combinational ready: a full entry can be replaced while it drains.
      assign w_in_ready = ~main_valid_q | out_ready;
      assign w_in_fire  = in_valid & w_in_ready;
      assign w_out_fire = main_valid_q & out_ready;

      always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_ctrl_d  = main_ctrl_q;
        if (w_in_fire) begin
          main_valid_d = 1'b1;
          main_data_d  = in_data;
          main_ctrl_d  = in_ctrl;
        end else if (w_out_fire) begin
          main_valid_d = 1'b0;
        end
        if (flush) begin
          main_valid_d = 1'b0;
          main_data_d  = '0;
          main_ctrl_d  = '0;
        end
      end

      always_ff @(negedge clk) begin
        if (rst) begin
          main_valid_q <= 1'b0;
          main_data_q  <= '0;
          main_ctrl_q  <= '0;
        end else begin
          main_valid_q <= main_valid_d;
          main_data_q  <= main_data_d;
          main_ctrl_q  <= main_ctrl_d;
        end
      end

      assign w_main_valid = main_valid_q;
      assign w_main_data  = main_data_q;
      assign w_main_ctrl  = main_ctrl_q;
    end
  endgenerate

  // Stall counter: saturates instead of wrapping; only rst clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (w_main_valid && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  generate
    if (GATE_CTRL != 0) begin : g_gate
      assign out_ctrl = w_main_valid ? w_main_ctrl : '0;
    end else begin : g_nogate
      assign out_ctrl = w_main_ctrl;
    end
  endgenerate

  assign in_ready  = w_in_ready;
  assign out_valid = w_main_valid;
  assign out_data  = w_main_data;
  assign stall_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_reg_hs.sv
// ============================================================================
// Module   : tb_pipe_reg_hs
// Purpose  : Self-checking bench for pipe_reg_hs. dut0 uses the default
//            configuration (skid entry, 8-bit counter) and is checked every
//            cycle against a queue-based reference; dut1 (no skid, 4-bit
//            counter) covers combinational ready and counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_reg_hs;

  typedef struct packed {
    logic [127:0] d;
    logic [15:0]  c;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- dut0: default configuration ----------------
  logic         rst0, flush0, iv0, rdy0, ov0, ordy0;
  logic [127:0] id0, od0;
  logic [15:0]  ic0, oc0;
  logic [7:0]   stall0;

  pipe_reg_hs dut0 (
    .clk(clk), .rst(rst0), .flush(flush0),
    .in_valid(iv0), .in_ready(rdy0), .in_data(id0), .in_ctrl(ic0),
    .out_valid(ov0), .out_ready(ordy0), .out_data(od0), .out_ctrl(oc0),
    .stall_cnt(stall0)
  );

  // ---------------- dut1: single entry, 4-bit counter ----------------
  logic       rst1, flush1, iv1, rdy1, ov1, ordy1;
  logic [7:0] id1, od1;
  logic [3:0] ic1, oc1;
  logic [3:0] stall1;

  pipe_reg_hs #(.DATA_W(8), .CTRL_W(4), .SKID(0), .GATE_CTRL(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst1), .flush(flush1),
    .in_valid(iv1), .in_ready(rdy1), .in_data(id1), .in_ctrl(ic1),
    .out_valid(ov1), .out_ready(ordy1), .out_data(od1), .out_ctrl(oc1),
    .stall_cnt(stall1)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model for dut0 ----------------
  // Stage contents as an ordered list of accepted, not yet consumed words.
  ent_t         q[$];
  logic [127:0] last_d = '0;   // data left in main once it drains
  int           m_cnt  = 0;
  logic         pend   = 1'b0;
  ent_t         pend_e;

  // Stimulus side: an accepted word becomes expected output after the edge.
  always @(posedge clk) begin
    pend   = !rst0 && !flush0 && iv0 && rdy0;
    pend_e = '{d: id0, c: ic0};
  end
  always @(negedge clk) begin
    if (pend) q.push_back(pend_e);
    pend = 1'b0;
  end

  // Monitor: compares DUT outputs with the model, pops on each transfer.
  always @(posedge clk) begin : monitor
    int sz;
    sz = q.size();
    if (rst0) begin
      q.delete();
      last_d = '0;
      m_cnt  = 0;
    end else begin
      chk("out_valid", ov0, sz != 0);
      chk("in_ready", rdy0, sz < 2);
      chk("stall_cnt", stall0, m_cnt);
      if (sz != 0) begin
        chk("out_data", od0, q[0].d);
        chk("out_ctrl", oc0, q[0].c);
        if (!ordy0 && m_cnt < 255) m_cnt++;
        if (ov0 && ordy0) last_d = q.pop_front().d;
      end else begin
        chk("idle_data", od0, last_d);
        chk("idle_ctrl_gated", oc0, 0);
      end
      if (flush0) begin
        q.delete();
        last_d = '0;
      end
    end
  end

  // ---------------- driver helpers ----------------
  logic last_acc = 1'b0;

  task automatic tick();
    @(posedge clk);
    last_acc = iv0 && rdy0;
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic hold;
    rst0 = 1'b1; flush0 = 1'b0; iv0 = 1'b0; id0 = '0; ic0 = '0; ordy0 = 1'b1;
    rst1 = 1'b1; flush1 = 1'b0; iv1 = 1'b0; id1 = '0; ic1 = '0; ordy1 = 1'b1;

    // Reset for two cycles, then release.
    tick(); tick();
    rst0 = 1'b0;
    tick();
    chk("rst_out_valid", ov0, 0);
    chk("rst_out_ctrl", oc0, 0);
    chk("rst_stall_cnt", stall0, 0);
    chk("rst_in_ready", rdy0, 1);

    // Back-to-back stream, one-cycle latency, no bubbles.
    ordy0 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      iv0 = 1'b1; id0 = 128'(k * 'h11); ic0 = 16'(k);
      tick();
      chk("stream_valid", ov0, 1);
      chk("stream_data", od0, k * 'h11);
    end
    iv0 = 1'b0;
    tick();

    // Skid: A1 in main, B2 into skid, C3 held upstream.
    ordy0 = 1'b0; iv0 = 1'b1; id0 = 'hA1; ic0 = 16'h0001;
    tick();
    id0 = 'hB2; ic0 = 16'h0002;
    tick();
    id0 = 'hC3; ic0 = 16'h0003;
    tick();
    chk("skid_in_ready_low", rdy0, 0);
    chk("skid_main_held", od0, 'hA1);
    tick(); tick();
    ordy0 = 1'b1;
    begin : wait_c3
      for (int n = 0; n < 10; n++) begin
        tick();
        if (last_acc) disable wait_c3;
      end
      chk("skid_c3_accept_timeout", 0, 1);
    end
    iv0 = 1'b0;
    tick();
    chk("skid_stall_cnt", stall0, 4);

    // Flush while in SKIDF with a word on the input.
    ordy0 = 1'b0; iv0 = 1'b1; id0 = 'hD1; ic0 = 16'h00D1;
    tick();
    id0 = 'hD2; ic0 = 16'h00D2;
    tick();
    flush0 = 1'b1; ordy0 = 1'b1; id0 = 'hEE; ic0 = 16'h00EE;
    tick();
    flush0 = 1'b0; iv0 = 1'b0;
    chk("flush_out_valid", ov0, 0);
    chk("flush_out_ctrl", oc0, 0);
    chk("flush_in_ready", rdy0, 1);
    chk("flush_stall_cnt", stall0, 5);
    tick();
    chk("flush_discard", ov0, 0);

    // Control gating while idle.
    iv0 = 1'b0; ic0 = 16'hFFFF;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("gate_ctrl", oc0, 0);
    end

    // Randomised traffic, honouring the hold-until-ready upstream rule.
    for (int i = 0; i < 3000; i++) begin
      hold   = iv0 && !last_acc && !flush0 && !rst0;
      rst0   = ($urandom_range(0, 299) == 0);
      ordy0  = ($urandom_range(0, 3) != 0);
      flush0 = ordy0 && ($urandom_range(0, 39) == 0);
      if (!hold) begin
        iv0 = ($urandom_range(0, 2) != 0);
        id0 = {$urandom(), $urandom(), $urandom(), $urandom()};
        ic0 = 16'($urandom());
      end
      tick();
    end
    rst0 = 1'b0; flush0 = 1'b0; iv0 = 1'b0; ordy0 = 1'b1;
    tick();

    // ---------------- dut1 directed checks ----------------
    rst1 = 1'b0;
    tick();
    chk("d1_rst_valid", ov1, 0);
    chk("d1_rst_ready", rdy1, 1);
    chk("d1_rst_stall", stall1, 0);
    ordy1 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      iv1 = 1'b1; id1 = 8'(k * 'h11); ic1 = 4'(k);
      tick();
      chk("d1_stream_valid", ov1, 1);
      chk("d1_stream_data", od1, k * 'h11);
      chk("d1_stream_ctrl", oc1, k);
    end
    iv1 = 1'b0; ordy1 = 1'b0;
    tick();
    chk("d1_ready_full_stall", rdy1, 0);
    ordy1 = 1'b1;
    #1;
    chk("d1_ready_comb", rdy1, 1);
    ordy1 = 1'b0;
    #1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("d1_stall_sat", stall1, (i + 1 > 15) ? 15 : i + 1);
    end
    chk("d1_held_data", od1, 'h44);
    rst1 = 1'b1;
    tick();
    chk("d1_midstall_rst_cnt", stall1, 0);
    chk("d1_midstall_rst_valid", ov1, 0);
    chk("d1_midstall_rst_ctrl", oc1, 0);
    rst1 = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
